// File: rtl/counter_scheduler.sv
// -----------------------------------------------------------------------------
// counter_scheduler
//
// Round-robin scheduler that time-shares a single interval counter among
// NUM_REQ requesters. One requester at a time is granted; its latched interval
// length is counted out (advancing only while en is high), its done line is
// pulsed for one cycle, and the block returns to IDLE to re-arbitrate.
//
// Ports:
//   clk        in   1                    rising-edge clock
//   rst        in   1                    asynchronous active-low reset
//   en         in   1                    global count enable
//   req        in   NUM_REQ              per-requester request level
//   len        in   NUM_REQ*COUNT_WIDTH  per-requester interval length
//   gnt        out  NUM_REQ              one-hot grant (registered)
//   done       out  NUM_REQ              one-cycle completion pulse (registered)
//   busy       out  1                    high in RUN or DONE (registered)
//   active_id  out  ID_WIDTH             granted requester index, 0 when idle
//   count      out  COUNT_WIDTH          current shared count
// -----------------------------------------------------------------------------
module counter_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int COUNT_WIDTH = 8,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] len,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [ID_WIDTH-1:0]            active_id,
  output logic [COUNT_WIDTH-1:0]         count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0]     REQ_ZERO = {NUM_REQ{1'b0}};
  localparam logic [NUM_REQ-1:0]     REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [ID_WIDTH-1:0]    ID_ZERO  = {ID_WIDTH{1'b0}};
  // Pointing at the last requester makes requester 0 the first one searched.
  localparam logic [ID_WIDTH-1:0]    ID_LAST  = ID_WIDTH'(NUM_REQ - 1);

  state_t                 state_r;
  logic [NUM_REQ-1:0]     gnt_r;
  logic [NUM_REQ-1:0]     done_r;
  logic                   busy_r;
  logic [ID_WIDTH-1:0]    active_id_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [COUNT_WIDTH-1:0] target_r;
  logic [ID_WIDTH-1:0]    rr_ptr_r;

  logic                   found_s;
  logic [ID_WIDTH-1:0]    win_s;
  logic [ID_WIDTH-1:0]    idx_s;
  logic [COUNT_WIDTH-1:0] len_win_s;
  logic [NUM_REQ-1:0]     win_onehot_s;
  logic                   req_active_s;

  // Round-robin search: first requesting index after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = ID_ZERO;
    idx_s   = ID_ZERO;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = ID_WIDTH'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Length of the arbitration winner and level of the granted requester's req.
  always_comb begin
    len_win_s    = CNT_ZERO;
    req_active_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_s == ID_WIDTH'(i)) begin
        len_win_s = len[i*COUNT_WIDTH +: COUNT_WIDTH];
      end else begin
        len_win_s = len_win_s;
      end
      if (active_id_r == ID_WIDTH'(i)) begin
        req_active_s = req[i];
      end else begin
        req_active_s = req_active_s;
      end
    end
    win_onehot_s = REQ_ONE << win_s;
  end

  // Scheduler state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      gnt_r       <= REQ_ZERO;
      done_r      <= REQ_ZERO;
      busy_r      <= 1'b0;
      active_id_r <= ID_ZERO;
      count_r     <= CNT_ZERO;
      target_r    <= CNT_ZERO;
      rr_ptr_r    <= ID_LAST;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            gnt_r       <= win_onehot_s;
            active_id_r <= win_s;
            rr_ptr_r    <= win_s;
            target_r    <= len_win_s;
            count_r     <= CNT_ZERO;
            busy_r      <= 1'b1;
            // A zero-length interval completes on the grant edge itself.
            if (len_win_s == CNT_ZERO) begin
              state_r <= ST_DONE;
              done_r  <= win_onehot_s;
            end else begin
              state_r <= ST_RUN;
              done_r  <= REQ_ZERO;
            end
          end else begin
            state_r     <= ST_IDLE;
            gnt_r       <= REQ_ZERO;
            done_r      <= REQ_ZERO;
            busy_r      <= 1'b0;
            active_id_r <= ID_ZERO;
            count_r     <= CNT_ZERO;
          end
        end
        ST_RUN: begin
          // Abort takes priority over counting; no done is pulsed.
          if (!req_active_s) begin
            state_r     <= ST_IDLE;
            gnt_r       <= REQ_ZERO;
            done_r      <= REQ_ZERO;
            busy_r      <= 1'b0;
            active_id_r <= ID_ZERO;
            count_r     <= CNT_ZERO;
          end else if (en && (count_r == (target_r - CNT_ONE))) begin
            state_r <= ST_DONE;
            count_r <= target_r;
            done_r  <= gnt_r;
          end else if (en) begin
            count_r <= count_r + CNT_ONE;
          end else begin
            count_r <= count_r;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          gnt_r       <= REQ_ZERO;
          done_r      <= REQ_ZERO;
          busy_r      <= 1'b0;
          active_id_r <= ID_ZERO;
          count_r     <= CNT_ZERO;
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_r       <= REQ_ZERO;
          done_r      <= REQ_ZERO;
          busy_r      <= 1'b0;
          active_id_r <= ID_ZERO;
          count_r     <= CNT_ZERO;
          target_r    <= CNT_ZERO;
          rr_ptr_r    <= ID_LAST;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign active_id = active_id_r;
  assign count     = count_r;

endmodule

// File: tb/tb_counter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_scheduler
//
// Directed, table-driven bench for counter_scheduler (NUM_REQ=4, COUNT_WIDTH=8).
// Each table row gives the inputs applied before a rising edge and the outputs
// expected just after it. Hand-written sequences cover asynchronous reset in
// the middle of a run and the maximum interval length.
// -----------------------------------------------------------------------------
module tb_counter_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  active_id;
  logic [7:0]  count;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  id;
    logic [7:0]  count;
  } vec_t;

  vec_t vecs[$];

  counter_scheduler #(.NUM_REQ(4), .COUNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .len       (len),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .active_id (active_id),
    .count     (count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] eg,
                           input logic [3:0] ed, input logic eb, input logic [1:0] ei,
                           input logic [7:0] ec);
    check({tag, ".gnt"},   idx, 32'(gnt),       32'(eg));
    check({tag, ".done"},  idx, 32'(done),      32'(ed));
    check({tag, ".busy"},  idx, 32'(busy),      32'(eb));
    check({tag, ".id"},    idx, 32'(active_id), 32'(ei));
    check({tag, ".count"}, idx, 32'(count),     32'(ec));
  endtask

  task automatic add(input logic r, input logic e, input logic [3:0] rq,
                     input logic [31:0] l, input logic [3:0] eg, input logic [3:0] ed,
                     input logic eb, input logic [1:0] ei, input logic [7:0] ec);
    vec_t v;
    v.rst = r; v.en = e; v.req = rq; v.len = l;
    v.gnt = eg; v.done = ed; v.busy = eb; v.id = ei; v.count = ec;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] l_rr;
    logic [31:0] l_ab;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    en  = 1'b0;
    req = 4'b0000;
    len = 32'h0000_0000;

    l_rr = 32'h0101_0101;
    l_ab = 32'h0200_0A00;

    //    rst   en    req      len           gnt      done     busy  id    count
    // reset state
    add(1'b0, 1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    // req0, len0=3
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0003, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd0);
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0003, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd1);
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0003, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd2);
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0003, 4'b0001, 4'b0001, 1'b1, 2'd0, 8'd3);
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0003, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    // reset back so round robin starts at requester 0
    add(1'b0, 1'b1, 4'b0000, l_rr,          4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    // all requests held, all len=1: order 0,1,2,3,0
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0001, 4'b0000, 1'b1, 2'd0, 8'd0);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0001, 4'b0001, 1'b1, 2'd0, 8'd1);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0010, 4'b0000, 1'b1, 2'd1, 8'd0);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0010, 4'b0010, 1'b1, 2'd1, 8'd1);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0100, 4'b0000, 1'b1, 2'd2, 8'd0);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0100, 4'b0100, 1'b1, 2'd2, 8'd1);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b1000, 4'b0000, 1'b1, 2'd3, 8'd0);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b1000, 4'b1000, 1'b1, 2'd3, 8'd1);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    add(1'b1, 1'b1, 4'b1111, l_rr,          4'b0001, 4'b0000, 1'b1, 2'd0, 8'd0);
    // drop req0 in RUN: abort, no done
    add(1'b1, 1'b1, 4'b0000, l_rr,          4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    // req0 len0=4 with en toggling
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0004, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd0);
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0004, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd1);
    add(1'b1, 1'b0, 4'b0001, 32'h0000_0004, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd1);
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0004, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd2);
    add(1'b1, 1'b0, 4'b0001, 32'h0000_0004, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd2);
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0004, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd3);
    add(1'b1, 1'b0, 4'b0001, 32'h0000_0004, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd3);
    add(1'b1, 1'b1, 4'b0001, 32'h0000_0004, 4'b0001, 4'b0001, 1'b1, 2'd0, 8'd4);
    add(1'b1, 1'b1, 4'b0000, 32'h0000_0004, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    // req2 len2=0: grant and done on the same edge
    add(1'b1, 1'b1, 4'b0100, 32'h0000_0000, 4'b0100, 4'b0100, 1'b1, 2'd2, 8'd0);
    add(1'b1, 1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    // req1 len1=10, req3 arrives and waits, req1 drops at count=5
    add(1'b1, 1'b1, 4'b0010, l_ab,          4'b0010, 4'b0000, 1'b1, 2'd1, 8'd0);
    add(1'b1, 1'b1, 4'b1010, l_ab,          4'b0010, 4'b0000, 1'b1, 2'd1, 8'd1);
    add(1'b1, 1'b1, 4'b1010, l_ab,          4'b0010, 4'b0000, 1'b1, 2'd1, 8'd2);
    add(1'b1, 1'b1, 4'b1010, l_ab,          4'b0010, 4'b0000, 1'b1, 2'd1, 8'd3);
    add(1'b1, 1'b1, 4'b1010, l_ab,          4'b0010, 4'b0000, 1'b1, 2'd1, 8'd4);
    add(1'b1, 1'b1, 4'b1010, l_ab,          4'b0010, 4'b0000, 1'b1, 2'd1, 8'd5);
    add(1'b1, 1'b1, 4'b1000, l_ab,          4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    add(1'b1, 1'b1, 4'b1000, l_ab,          4'b1000, 4'b0000, 1'b1, 2'd3, 8'd0);
    add(1'b1, 1'b1, 4'b0000, l_ab,          4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      req = vecs[i].req;
      len = vecs[i].len;
      step();
      check_all("vec", i, vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].id,
                vecs[i].count);
    end

    // Asynchronous reset mid-RUN at count=6.
    rst = 1'b1;
    en  = 1'b1;
    req = 4'b0001;
    len = 32'h0000_000A;
    begin
      int budget;
      budget = 0;
      step();
      while (count != 8'd6 && budget < 20) begin
        step();
        budget++;
      end
      check("arst.reach6", 0, 32'(count), 32'd6);
      check("arst.busy_pre", 0, 32'(busy), 32'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    check_all("arst", 0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    step();
    check_all("arst_hold", 0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    rst = 1'b1;
    req = 4'b1010;
    len = 32'h0500_0500;
    step();
    check_all("arst_after", 0, 4'b0010, 4'b0000, 1'b1, 2'd1, 8'd0);
    req = 4'b0000;
    step();
    check_all("arst_abort", 0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);

    // Maximum length 255: counts to 255 with no wrap and no early done.
    req = 4'b0001;
    len = 32'h0000_00FF;
    en  = 1'b1;
    step();
    check_all("max_grant", 0, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd0);
    for (int k = 1; k <= 254; k++) begin
      step();
      if (k == 100 || k == 254) begin
        check_all("max_run", k, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'(k));
      end else begin
        check("max_done_low", k, 32'(done), 32'd0);
      end
    end
    step();
    check_all("max_done", 0, 4'b0001, 4'b0001, 1'b1, 2'd0, 8'd255);
    req = 4'b0000;
    step();
    check_all("max_idle", 0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
